// File: rtl/idct_pkg.sv
// Shared definitions for the iCDT-side stages: block geometry, writer states and
// the round-half-up / saturate helper.
package idct_pkg;

  localparam int BLK      = 8;
  localparam int BLK_LOG2 = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  // Low acc_w bits of x are a signed value; drop shift fractional bits rounding half
  // toward +inf, then clamp to the signed dw-bit range. 64-bit math never overflows.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] x,
                                                   input int acc_w,
                                                   input int shift,
                                                   input int dw);
    logic signed [63:0] x_ext;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    x_ext = (x <<< (64 - acc_w)) >>> (64 - acc_w);
    r     = (x_ext + (64'sd1 <<< (shift - 1))) >>> shift;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      return hi;
    end
    if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/idct_round_sat.sv
// Combinational round + saturate of one iCDT accumulator value to a DW-bit sample.
module idct_round_sat
  import idct_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 8,
  parameter int DW    = 16
) (
  input  logic signed [ACC_W-1:0] data_i,
  output logic signed [DW-1:0]    data_o
);

  assign data_o = DW'(sat_round(64'(data_i), ACC_W, SHIFT, DW));

endmodule

// File: rtl/idct_result_writer.sv
// Packs rounded iCDT samples into horizontal pairs and writes them to the result memory
// at raster image addresses; pulses done after the last block of a frame.
module idct_result_writer
  import idct_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 8,
  parameter int DW    = 16,
  parameter int AW    = 18,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic [2:0]              in_i,
  input  logic [2:0]              in_j,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [2*DW-1:0]         wr_data,
  output logic                    done,
  output logic                    err
);

  localparam int NBX = IMG_W / BLK;
  localparam int NBY = IMG_H / BLK;
  localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int BYW = (NBY > 1) ? $clog2(NBY) : 1;
  localparam logic [BXW-1:0] BX_LAST = BXW'(NBX - 1);
  localparam logic [BYW-1:0] BY_LAST = BYW'(NBY - 1);

  state_e           state_q, state_d;
  logic [2:0]       i_q, i_d;
  logic [2:0]       j_q, j_d;
  logic [BXW-1:0]   bx_q, bx_d;
  logic [BYW-1:0]   by_q, by_d;
  logic [DW-1:0]    pack_q, pack_d;
  logic             err_q, err_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [2*DW-1:0]  wr_data_q, wr_data_d;

  logic signed [DW-1:0] sat;
  logic                 accept;
  logic                 last_sample;

  idct_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .DW    (DW)
  ) u_round_sat (
    .data_i (in_data),
    .data_o (sat)
  );

  assign in_ready    = (state_q == RUN);
  assign accept      = in_valid & in_ready;
  assign last_sample = (i_q == 3'd7) && (j_q == 3'd7) && (bx_q == BX_LAST) && (by_q == BY_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    bx_d      = bx_q;
    by_d      = by_q;
    pack_d    = pack_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          bx_d    = '0;
          by_d    = '0;
          pack_d  = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          // The sample always lands at the internally expected position.
          if ((in_i != i_q) || (in_j != j_q)) begin
            err_d = 1'b1;
          end
          if (j_q[0]) begin
            wr_en_d   = 1'b1;
            wr_data_d = {sat, pack_q};
            wr_addr_d = AW'((((32'(by_q) << BLK_LOG2) + 32'(i_q)) * 32'(IMG_W)
                             + (32'(bx_q) << BLK_LOG2) + 32'(j_q) - 32'd1) >> 1);
          end else begin
            pack_d = sat;
          end
          j_d = j_q + 3'd1;
          if (j_q == 3'd7) begin
            i_d = i_q + 3'd1;
            if (i_q == 3'd7) begin
              if (bx_q == BX_LAST) begin
                bx_d = '0;
                by_d = (by_q == BY_LAST) ? '0 : by_q + 1'b1;
              end else begin
                bx_d = bx_q + 1'b1;
              end
            end
          end
          if (last_sample) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      pack_q    <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      pack_q    <= pack_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = (state_q == DONE);
  assign err     = err_q;

endmodule
